// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one external adder between two requesters
module adder_share_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             req1_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             gate_en,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic last_grant, grant0, grant1;
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_grant);
    grant1     = req1_valid && (!req0_valid || !last_grant);
    req0_ready = !rst && state == IDLE && grant0;
    req1_ready = !rst && state == IDLE && grant1;
    gate_en    = state == EXEC;
    busy       = state != IDLE;
    state_nx   = state == IDLE ? ((grant0 || grant1) ? EXEC : IDLE) :
                 state == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
  end
  // last_grant doubles as the owner ID of the operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      add_a      <= '0;
      add_b      <= '0;
      add_cin    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_ovf    <= 1'b0;
    end else begin
      state <= state_nx;
      if (req0_ready || req1_ready) begin
        add_a      <= grant1 ? req1_a : req0_a;
        add_b      <= grant1 ? req1_b : req0_b;
        add_cin    <= grant1 ? req1_cin : req0_cin;
        last_grant <= grant1;
      end
      if (state == EXEC) begin
        rsp_sum   <= add_sum;
        rsp_cout  <= add_cout;
        rsp_ovf   <= (add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != add_a[WIDTH-1]);
        rsp_id    <= last_grant;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one external Adder_16bit instance between two requesters using a round-robin, valid/ready handshake.
- Registers the operands and drives them onto the adder, captures Sum/Cout/signed overflow, and returns the result on a shared response channel tagged with the requester ID.
- Outputs a clock-gate enable that is high only in the cycle the adder result is sampled. This supports the low-power clock-gated ALU.

Parameters:
- WIDTH, 16, operand and result width (must match the adder; only 16 is verified).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_a  input  WIDTH  requester 0 operand A (signed).
- req0_b  input  WIDTH  requester 0 operand B (signed).
- req0_cin  input  1  requester 0 carry-in.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req1_valid  input  1  requester 1 has an operation pending.
- req1_a  input  WIDTH  requester 1 operand A (signed).
- req1_b  input  WIDTH  requester 1 operand B (signed).
- req1_cin  input  1  requester 1 carry-in.
- req1_ready  output  1  requester 1 operation accepted this cycle.
- add_a  output  WIDTH  registered operand A to the adder.
- add_b  output  WIDTH  registered operand B to the adder.
- add_cin  output  1  registered carry-in to the adder.
- add_sum  input  WIDTH  adder Sum (combinational from add_*).
- add_cout  input  1  adder Cout.
- gate_en  output  1  clock-gate enable for the adder/result domain.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  1  requester that owns the result.
- rsp_sum  output  WIDTH  registered sum.
- rsp_cout  output  1  registered carry-out.
- rsp_ovf  output  1  registered signed overflow.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie).
  - add_a=0, add_b=0, add_cin=0.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0.
  - gate_en=0, busy=0, req*_ready=0.
  - Reset mid-operation aborts the operation and discards any pending response; no ready or valid is asserted afterwards for it.
- IDLE:
  - Grant is combinational:
    - only one valid: grant it.
    - both valid: grant the requester that is not last_grant.
  - reqN_ready = (state==IDLE) && grantN. Ready is never high in any other state, and never high for both requesters.
  - On the accepting edge: latch the granted a/b/cin into add_a/add_b/add_cin, set last_grant, record the ID, and go to EXEC.
  - With no valid input, stay in IDLE; add_* hold their previous values (no toggling).
- EXEC (exactly 1 cycle):
  - gate_en=1.
  - On the edge: rsp_sum<=add_sum, rsp_cout<=add_cout, rsp_ovf<=(add_a[15]==add_b[15]) && (add_sum[15]!=add_a[15]), rsp_id<=granted ID, rsp_valid<=1. Go to RESP.
- RESP:
  - rsp_valid=1; all rsp_* fields are held stable until rsp_ready=1 is sampled.
  - On that edge: rsp_valid<=0, go to IDLE.
  - New requests are not accepted in RESP; the next accept happens in IDLE at the earliest one cycle later.
- Latency: accept at edge T -> rsp_valid high after edge T+1. Minimum issue interval is 3 cycles.
- Requester protocol: valid plus operands must stay stable until ready is seen. Dropping valid before ready is legal and causes no grant.
- Arithmetic: two's complement, modulo 2^WIDTH. Cout and ovf are reported independently.
- gate_en is 0 in IDLE and RESP.

Test Plan:
- Reset: assert rst for 2 cycles mid-EXEC -> next cycle all outputs 0, state IDLE, no rsp_valid appears for the aborted operation.
- Single add: req0 a=0x1234, b=0x0001, cin=1 -> req0_ready for 1 cycle; 2 edges later rsp_valid=1, rsp_id=0, sum=0x1236, cout=0, ovf=0; gate_en high for exactly one cycle.
- Overflow/carry: req1 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, ovf=1, cout=0. Then a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, ovf=0.
- Fairness: both valid continuously after reset -> grant order 0,1,0,1; rsp_id alternates; req0_ready and req1_ready are never high together.
- Backpressure: rsp_ready=0 for 5 cycles with req0 valid -> rsp_* stable, req0_ready stays 0, busy=1; rsp_ready=1 -> IDLE next cycle, then req0 accepted.
- Idle power: no valid for 10 cycles -> gate_en=0 and add_a/add_b/add_cin hold their values throughout.
